// File: rtl/uart_tx_arb_ctrl_if.sv
// rtl/uart_tx_arb_ctrl_if.sv - requester, serializer and line signals of the arbitrated UART transmitter
interface uart_tx_arb_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  A_VALID;
  logic [DATA_WIDTH-1:0] A_DATA;
  logic                  B_VALID;
  logic [DATA_WIDTH-1:0] B_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  SER_DONE;
  logic                  SER_DATA;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  SER_EN;
  logic                  A_GNT;
  logic                  B_GNT;
  logic                  TX_OUT;
  logic                  BUSY;
  logic                  ERR;

  modport master (
    output A_VALID, A_DATA, B_VALID, B_DATA, PAR_EN, PAR_TYP, SER_DONE, SER_DATA,
    input  P_DATA, SER_EN, A_GNT, B_GNT, TX_OUT, BUSY, ERR
  );

  modport slave (
    input  A_VALID, A_DATA, B_VALID, B_DATA, PAR_EN, PAR_TYP, SER_DONE, SER_DATA,
    output P_DATA, SER_EN, A_GNT, B_GNT, TX_OUT, BUSY, ERR
  );
endinterface

// File: rtl/uart_tx_arb_ctrl.sv
// rtl/uart_tx_arb_ctrl.sv - two-requester round-robin UART frame controller with parity and done timeout
module uart_tx_arb_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_arb_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  last_b_q, last_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  gnt_a, gnt_b;
  logic                  ser_en, tx;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      last_b_q  <= 1'b1;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_data_q  <= p_data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      last_b_q  <= last_b_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_data_d  = p_data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    last_b_d  = last_b_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    ser_en    = 1'b0;
    tx        = 1'b1;

    // Grants are gated by RST so no pulse can leak out while reset holds the FSM in IDLE.
    if (RST && (state_q == S_IDLE || state_q == S_STOP)) begin
      if (bus.A_VALID && bus.B_VALID) begin
        gnt_a = last_b_q;
        gnt_b = !last_b_q;
      end else begin
        gnt_a = bus.A_VALID;
        gnt_b = bus.B_VALID;
      end
    end

    case (state_q)
      S_IDLE, S_STOP: begin
        if (gnt_a || gnt_b) begin
          state_d   = S_START;
          p_data_d  = gnt_a ? bus.A_DATA : bus.B_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          last_b_d  = gnt_b;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tx      = 1'b0;
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        ser_en = 1'b1;
        tx     = bus.SER_DATA;
        cnt_d  = cnt_q + CNT_W'(1);
        // A completion arriving on the final allowed cycle still counts as a good frame.
        if (bus.SER_DONE) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_STOP;
        end
      end
      S_PARITY: begin
        tx      = (^p_data_q) ^ par_typ_q;
        state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.P_DATA = p_data_q;
  assign bus.SER_EN = ser_en;
  assign bus.A_GNT  = gnt_a;
  assign bus.B_GNT  = gnt_b;
  assign bus.TX_OUT = tx;
  assign bus.BUSY   = (state_q != S_IDLE);
  assign bus.ERR    = err_q;
endmodule

// File: tb/tb_uart_tx_arb_ctrl.sv
// tb/tb_uart_tx_arb_ctrl.sv - directed scoreboard bench for uart_tx_arb_ctrl
module tb_uart_tx_arb_ctrl;
  logic CLK;
  logic RST;
  int   vectors     = 0;
  int   miscompares = 0;
  logic sb[$];

  uart_tx_arb_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_arb_ctrl #(.DATA_WIDTH(8), .DONE_TIMEOUT(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tx(input string tag);
    logic e;
    e = (sb.size() > 0) ? sb.pop_front() : 1'bz;
    chk(tag, bus.TX_OUT, e);
  endtask

  // Entered at an accept-point sample with requests already driven; returns at the STOP sample.
  task automatic frame(input logic exp_b, input logic [7:0] d, input logic pen, input logic ptyp,
                       input int ndata, input logic done, input logic hold);
    logic sbits [16];
    chk("a_gnt", bus.A_GNT, !exp_b);
    chk("b_gnt", bus.B_GNT, exp_b);
    sb.push_back(1'b0);
    for (int i = 0; i < ndata; i++) begin
      sbits[i] = 1'($urandom);
      sb.push_back(sbits[i]);
    end
    if (pen) sb.push_back((^d) ^ ptyp);
    sb.push_back(1'b1);

    tick();
    if (!hold) begin
      bus.A_VALID = 1'b0;
      bus.B_VALID = 1'b0;
    end
    #1;
    chk_tx("start_tx");
    chk("start_ser_en", bus.SER_EN, 1'b0);
    chk("p_data", bus.P_DATA, d);
    chk("start_gnt", bus.A_GNT | bus.B_GNT, 1'b0);
    for (int i = 0; i < ndata; i++) begin
      tick();
      bus.SER_DATA = sbits[i];
      bus.SER_DONE = done && (i == ndata - 1);
      #1;
      chk_tx("data_tx");
      chk("data_ser_en", bus.SER_EN, 1'b1);
    end
    tick();
    bus.SER_DONE = 1'b0;
    if (pen) begin
      bus.SER_DONE = 1'b1;
      #1;
      chk_tx("parity_tx");
      chk("parity_ser_en", bus.SER_EN, 1'b0);
      tick();
      bus.SER_DONE = 1'b0;
    end
    #1;
    chk_tx("stop_tx");
    chk("stop_busy", bus.BUSY, 1'b1);
    chk("stop_ser_en", bus.SER_EN, 1'b0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    RST          = 1'b0;
    bus.A_VALID  = 1'b0;
    bus.A_DATA   = '0;
    bus.B_VALID  = 1'b0;
    bus.B_DATA   = '0;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.SER_DONE = 1'b0;
    bus.SER_DATA = 1'b0;
    #1;
    bus.A_VALID = 1'b1;
    #1;
    chk("rst_tx", bus.TX_OUT, 1'b1);
    chk("rst_ser_en", bus.SER_EN, 1'b0);
    chk("rst_a_gnt", bus.A_GNT, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_err", bus.ERR, 1'b0);
    chk("rst_p_data", bus.P_DATA, 8'h00);
    tick();
    #1;
    chk("rst_hold_busy", bus.BUSY, 1'b0);
    bus.A_VALID = 1'b0;
    RST = 1'b1;

    tick();
    bus.SER_DONE = 1'b1;
    #1;
    chk("idle_done_busy", bus.BUSY, 1'b0);
    chk("idle_tx", bus.TX_OUT, 1'b1);
    tick();
    bus.SER_DONE = 1'b0;
    #1;
    chk("idle_done_after", bus.BUSY, 1'b0);

    // Single A frame, no parity, done after nine data cycles
    bus.A_DATA = 8'hA5; bus.PAR_EN = 1'b0; bus.A_VALID = 1'b1;
    #1;
    frame(1'b0, 8'hA5, 1'b0, 1'b0, 9, 1'b1, 1'b0);
    tick(); #1;
    chk("idle_after_a_busy", bus.BUSY, 1'b0);
    chk("idle_after_a_tx", bus.TX_OUT, 1'b1);
    chk("idle_after_a_err", bus.ERR, 1'b0);

    // B alone, even then odd parity
    bus.B_DATA = 8'h07; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.B_VALID = 1'b1;
    #1;
    frame(1'b1, 8'h07, 1'b1, 1'b0, 9, 1'b1, 1'b0);
    tick(); #1;
    chk("idle_after_b_even", bus.BUSY, 1'b0);
    bus.PAR_TYP = 1'b1; bus.B_VALID = 1'b1;
    #1;
    frame(1'b1, 8'h07, 1'b1, 1'b1, 9, 1'b1, 1'b0);
    tick(); #1;
    chk("idle_after_b_odd", bus.BUSY, 1'b0);

    // Continuous contention: A, B, A, B back-to-back
    bus.A_DATA = 8'h3C; bus.B_DATA = 8'hC3; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
    bus.A_VALID = 1'b1; bus.B_VALID = 1'b1;
    #1;
    frame(1'b0, 8'h3C, 1'b1, 1'b1, 8, 1'b1, 1'b1);
    frame(1'b1, 8'hC3, 1'b1, 1'b1, 8, 1'b1, 1'b1);
    frame(1'b0, 8'h3C, 1'b1, 1'b1, 8, 1'b1, 1'b1);
    frame(1'b1, 8'hC3, 1'b1, 1'b1, 8, 1'b1, 1'b0);
    tick(); #1;
    chk("idle_after_rr", bus.BUSY, 1'b0);

    // Done never arrives: timeout after fifteen data cycles, error is sticky
    bus.A_DATA = 8'h5A; bus.PAR_EN = 1'b0; bus.A_VALID = 1'b1;
    #1;
    frame(1'b0, 8'h5A, 1'b0, 1'b0, 15, 1'b0, 1'b0);
    chk("timeout_err", bus.ERR, 1'b1);
    tick(); #1;
    chk("timeout_idle", bus.BUSY, 1'b0);
    bus.B_DATA = 8'h81; bus.B_VALID = 1'b1;
    #1;
    frame(1'b1, 8'h81, 1'b0, 1'b0, 4, 1'b1, 1'b0);
    chk("err_sticky", bus.ERR, 1'b1);
    tick(); #1;

    // Reset during DATA abandons the frame
    bus.A_DATA = 8'h99; bus.A_VALID = 1'b1;
    #1;
    chk("pre_rst_a_gnt", bus.A_GNT, 1'b1);
    tick();
    bus.A_VALID = 1'b0;
    tick();
    bus.SER_DATA = 1'b0;
    #1;
    chk("pre_rst_ser_en", bus.SER_EN, 1'b1);
    RST = 1'b0;
    #1;
    chk("mid_rst_tx", bus.TX_OUT, 1'b1);
    chk("mid_rst_ser_en", bus.SER_EN, 1'b0);
    chk("mid_rst_busy", bus.BUSY, 1'b0);
    chk("mid_rst_err", bus.ERR, 1'b0);
    chk("mid_rst_p_data", bus.P_DATA, 8'h00);
    RST = 1'b1;
    tick(); #1;
    chk("no_regrant_busy", bus.BUSY, 1'b0);
    chk("no_regrant_a_gnt", bus.A_GNT, 1'b0);

    // Pointer back at B after reset, so A wins the first contention
    bus.A_DATA = 8'h66; bus.B_DATA = 8'h77; bus.A_VALID = 1'b1; bus.B_VALID = 1'b1;
    #1;
    frame(1'b0, 8'h66, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    tick(); #1;
    chk("final_idle", bus.BUSY, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
